// File: rtl/clock_gate_ctrl_pkg.sv
// Shared state encoding and widths for the clock-gate controller and its users.
// Pure declarations, no logic.
package clock_gate_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF   = 2'd0,
    ST_WAKE  = 2'd1,
    ST_ON    = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/clk_gate_idle_timer.sv
// Counts consecutive idle cycles; o_tc flags the last idle cycle before gating.
// Terminal count is combinational from the counter flop; clear has priority over enable.
module clk_gate_idle_timer #(
  parameter int IDLE_CYCLES = 16,
  localparam int W = $clog2(IDLE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != W'(IDLE_CYCLES))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tc = (cnt_q == W'(IDLE_CYCLES - 1));

endmodule

// File: rtl/clock_gate_ctrl.sv
// Decides when the gated domain's clock runs: wakes on activity, acks after WAKE_CYCLES,
// gates off after IDLE_CYCLES idle cycles. All outputs are flops; no input-to-output path.
module clock_gate_ctrl
  import clock_gate_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_busy,
  input  logic               i_wake_req,
  input  logic               i_force_on,
  output logic               o_clock_en,
  output logic               o_wake_ack,
  output logic [STATE_W-1:0] o_state,
  output logic [CNT_W-1:0]   o_gate_cnt
);

  localparam int WW = $clog2(WAKE_CYCLES + 1);

  state_e           state_q, state_d;
  logic [WW-1:0]    wake_cnt_q, wake_cnt_d;
  logic [CNT_W-1:0] gate_cnt_q, gate_cnt_d;
  logic             clock_en_q, clock_en_d;
  logic             wake_ack_q, wake_ack_d;
  logic             act;
  logic             idle_tc;
  logic             wake_done;

  assign act       = i_busy | i_wake_req | i_force_on;
  assign wake_done = (wake_cnt_q == WW'(WAKE_CYCLES - 1));

  // Any activity, or being outside ON, restarts the idle window from zero.
  clk_gate_idle_timer #(
    .IDLE_CYCLES(IDLE_CYCLES)
  ) u_idle_timer (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_clear (act | (state_q != ST_ON)),
    .i_enable((state_q == ST_ON) & ~act),
    .o_tc    (idle_tc)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_OFF:   if (act) state_d = ST_WAKE;
      ST_WAKE:  if (wake_done) state_d = ST_ON;
      ST_ON:    if (!act && idle_tc) state_d = ST_DRAIN;
      ST_DRAIN: state_d = act ? ST_ON : ST_OFF;
      default:  state_d = ST_OFF;
    endcase
  end

  // Enables are derived from the next state so they change on the same edge as the state.
  always_comb begin
    clock_en_d = (state_d != ST_OFF);
    wake_ack_d = (state_d == ST_ON);
    wake_cnt_d = '0;
    if ((state_q == ST_WAKE) && !wake_done) begin
      wake_cnt_d = wake_cnt_q + WW'(1);
    end
    gate_cnt_d = gate_cnt_q;
    if ((state_q == ST_DRAIN) && !act && (gate_cnt_q != {CNT_W{1'b1}})) begin
      gate_cnt_d = gate_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wake_cnt_q <= '0;
      gate_cnt_q <= '0;
      clock_en_q <= 1'b0;
      wake_ack_q <= 1'b0;
    end else begin
      wake_cnt_q <= wake_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      clock_en_q <= clock_en_d;
      wake_ack_q <= wake_ack_d;
    end
  end

  assign o_clock_en = clock_en_q;
  assign o_wake_ack = wake_ack_q;
  assign o_state    = state_q;
  assign o_gate_cnt = gate_cnt_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Scoreboard bench for clock_gate_ctrl with a latch-based gated clock standing in for
// clock_gating_model. Expected outputs are queued per cycle and checked at the falling edge.
module tb_clock_gate_ctrl;
  import clock_gate_ctrl_pkg::*;

  localparam int IDLE = 4;
  localparam int WAKE = 2;
  localparam int CW   = 2;

  logic clk = 1'b0;
  logic rst_n, busy, wake_req, force_on;
  logic clock_en, wake_ack;
  logic [STATE_W-1:0] state;
  logic [CW-1:0] gate_cnt;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int gclk_edges = 0;

  typedef struct {
    int          cyc;
    string       name;
    logic        en;
    logic        ack;
    logic [1:0]  st;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  clock_gate_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE),
    .CNT_W      (CW)
  ) dut (
    .i_clk     (clk),
    .i_rstn    (rst_n),
    .i_busy    (busy),
    .i_wake_req(wake_req),
    .i_force_on(force_on),
    .o_clock_en(clock_en),
    .o_wake_ack(wake_ack),
    .o_state   (state),
    .o_gate_cnt(gate_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gated clock: enable latched while clk is low, as an ICG cell would.
  logic en_lat = 1'b0;
  logic gclk;
  always @(clk or clock_en) if (!clk) en_lat = clock_en;
  assign gclk = clk & en_lat;
  always @(posedge gclk) gclk_edges++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(int d, string nm, logic en, logic ack, logic [1:0] st,
                          logic [CW-1:0] cnt);
    exp_t e;
    e.cyc  = cyc + d;
    e.name = nm;
    e.en   = en;
    e.ack  = ack;
    e.st   = st;
    e.cnt  = cnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Monitor: compare every queued expectation due this cycle, plus the ack/enable invariant.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s missed cycle %0d (now %0d)", e.name, e.cyc, cyc);
      end else if ({clock_en, wake_ack, state, gate_cnt} !== {e.en, e.ack, e.st, e.cnt}) begin
        failures++;
        $display("FAIL %s cyc=%0d actual en=%b ack=%b st=%0d cnt=%0d required en=%b ack=%b st=%0d cnt=%0d",
                 e.name, cyc, clock_en, wake_ack, state, gate_cnt, e.en, e.ack, e.st, e.cnt);
      end
    end
    if (wake_ack === 1'b1) begin
      checks++;
      if (clock_en !== 1'b1) begin
        failures++;
        $display("FAIL ack_implies_en cyc=%0d actual clock_en=%b required 1", cyc, clock_en);
      end
    end
  end

  initial begin
    int g0;
    rst_n    = 1'b0;
    busy     = 1'b0;
    wake_req = 1'b0;
    force_on = 1'b0;

    // Reset held ~100 ns
    repeat (9) tick();
    push_exp(1, "reset", 1'b0, 1'b0, ST_OFF, 2'd0);
    tick();
    tick();
    chk("reset_gclk_flat", gclk_edges, 0);
    rst_n = 1'b1;
    tick();

    // Wake, then idle down to OFF
    wake_req = 1'b1;
    push_exp(1, "wake_en",   1'b1, 1'b0, ST_WAKE,  2'd0);
    push_exp(2, "wake_mid",  1'b1, 1'b0, ST_WAKE,  2'd0);
    push_exp(3, "wake_ack",  1'b1, 1'b1, ST_ON,    2'd0);
    push_exp(6, "idle3",     1'b1, 1'b1, ST_ON,    2'd0);
    push_exp(7, "drain",     1'b1, 1'b0, ST_DRAIN, 2'd0);
    push_exp(8, "gate_off",  1'b0, 1'b0, ST_OFF,   2'd1);
    push_exp(9, "off_stay",  1'b0, 1'b0, ST_OFF,   2'd1);
    tick();
    wake_req = 1'b0;
    repeat (8) tick();

    // Busy pulse in DRAIN returns to ON and restarts the idle window
    busy = 1'b1;
    push_exp(1,  "b_wake",    1'b1, 1'b0, ST_WAKE,  2'd1);
    push_exp(3,  "b_on",      1'b1, 1'b1, ST_ON,    2'd1);
    push_exp(7,  "b_drain",   1'b1, 1'b0, ST_DRAIN, 2'd1);
    push_exp(8,  "drain_ret", 1'b1, 1'b1, ST_ON,    2'd1);
    push_exp(11, "idle_rst3", 1'b1, 1'b1, ST_ON,    2'd1);
    push_exp(12, "drain2",    1'b1, 1'b0, ST_DRAIN, 2'd1);
    push_exp(13, "gate_off2", 1'b0, 1'b0, ST_OFF,   2'd2);
    tick();
    busy = 1'b0;
    repeat (6) tick();
    busy = 1'b1;
    tick();
    busy = 1'b0;
    repeat (5) tick();

    // Request right after the DRAIN->OFF edge: one OFF cycle, then re-wake
    wake_req = 1'b1;
    push_exp(1, "rewake",    1'b1, 1'b0, ST_WAKE, 2'd2);
    push_exp(3, "rewake_on", 1'b1, 1'b1, ST_ON,   2'd2);
    tick();
    wake_req = 1'b0;
    tick();
    tick();

    // Force on for 200 ns: never gates
    force_on = 1'b1;
    for (int k = 1; k <= 20; k++) push_exp(k, "force_on", 1'b1, 1'b1, ST_ON, 2'd2);
    g0 = gclk_edges;
    repeat (20) tick();
    chk("force_gclk_edges", gclk_edges - g0, 20);
    force_on = 1'b0;
    push_exp(3, "post_force_on", 1'b1, 1'b1, ST_ON,    2'd2);
    push_exp(4, "post_force_dr", 1'b1, 1'b0, ST_DRAIN, 2'd2);
    push_exp(5, "gate_off3",     1'b0, 1'b0, ST_OFF,   2'd3);
    repeat (5) tick();

    // Gate counter saturates at all-ones
    busy = 1'b1;
    push_exp(1, "s_wake",  1'b1, 1'b0, ST_WAKE,  2'd3);
    push_exp(3, "s_on",    1'b1, 1'b1, ST_ON,    2'd3);
    push_exp(7, "s_drain", 1'b1, 1'b0, ST_DRAIN, 2'd3);
    push_exp(8, "sat_cnt", 1'b0, 1'b0, ST_OFF,   2'd3);
    tick();
    busy = 1'b0;
    repeat (7) tick();

    // Async reset mid-WAKE
    wake_req = 1'b1;
    tick();
    chk("pre_rst_en", clock_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_en",    clock_en, 0);
    chk("async_ack",   wake_ack, 0);
    chk("async_state", state, 0);
    push_exp(0, "rst_async", 1'b0, 1'b0, ST_OFF, 2'd0);
    tick();
    tick();
    rst_n = 1'b1;
    push_exp(1, "r_wake", 1'b1, 1'b0, ST_WAKE, 2'd0);
    push_exp(3, "r_on",   1'b1, 1'b1, ST_ON,   2'd0);
    tick();
    wake_req = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 30 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_queue actual=%0d pending required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
